// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared types and helpers for the BCD digit sequencer: run-state encoding,
// digit width and the wrap-aware single-step digit arithmetic.
package bcd_digit_sequencer_pkg;

    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned DEFAULT_MAX_VAL = 9;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } run_state_e;

    typedef struct packed {
        logic               wrap;
        logic [DIGIT_W-1:0] digit;
    } step_result_t;

    // One step of a 0..max_val ring counter in the requested direction.
    // The up-direction test uses >= so an out-of-range value can never
    // increment further into the 10..15 region.
    function automatic step_result_t step_digit(
        input logic [DIGIT_W-1:0] cur,
        input logic               up,
        input logic [DIGIT_W-1:0] max_val
    );
        step_result_t res;
        res.wrap  = 1'b0;
        res.digit = cur;
        if (up) begin
            if (cur >= max_val) begin
                res.digit = '0;
                res.wrap  = 1'b1;
            end else begin
                res.digit = cur + DIGIT_W'(1);
            end
        end else begin
            if (cur == '0) begin
                res.digit = max_val;
                res.wrap  = 1'b1;
            end else begin
                res.digit = cur - DIGIT_W'(1);
            end
        end
        return res;
    endfunction

    // Loaded values above max_val are replaced by 0 so the decoder never
    // sees an out-of-range digit.
    function automatic logic [DIGIT_W-1:0] clamp_load(
        input logic [DIGIT_W-1:0] val,
        input logic [DIGIT_W-1:0] max_val
    );
        return (val <= max_val) ? val : '0;
    endfunction

endpackage

// File: rtl/bcd_digit_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter that only
// accepts a new level after DEB_CYCLES consecutive differing samples, and a
// one-cycle pulse on each accepted rising edge. Reusable for any lab button.
module btn_debounce
    import bcd_digit_sequencer_pkg::*;
#(
    parameter int unsigned DEB_WIDTH  = 18,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic press
);

    localparam logic [DEB_WIDTH-1:0] DEB_TERM = DEB_WIDTH'(DEB_CYCLES - 1);

    logic [1:0]           sync_q;
    logic [1:0]           sync_d;
    logic                 level_q;
    logic                 level_d;
    logic                 edge_q;
    logic                 edge_d;
    logic [DEB_WIDTH-1:0] cnt_q;
    logic [DEB_WIDTH-1:0] cnt_d;
    logic                 sync_level;

    assign sync_level = sync_q[1];

    // Next-state: shift synchronizer, count disagreement, accept on terminal.
    always_comb begin
        sync_d  = {sync_q[0], btn_in};
        level_d = level_q;
        cnt_d   = cnt_q;
        edge_d  = level_q;
        if (sync_level == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= DEB_TERM) begin
            level_d = sync_level;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DEB_WIDTH'(1);
        end
    end

    // State registers for synchronizer, debounced level and edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    // Press is high for the single cycle after the debounced level rises.
    assign press = level_q & ~edge_q;

endmodule

// File: rtl/bcd_digit_sequencer.sv
// BCD digit sequencer feeding the 7-segment decoder. A debounced button
// toggles RUN/PAUSE; in RUN a prescaler produces a step every DIV_COUNT
// clocks and the digit moves up or down through 0..MAX_VAL with wrap
// indication. A synchronous load overrides stepping and restarts the
// prescaler without touching the run state. Reset release is expected to
// be synchronised to clk by the top level.
module bcd_digit_sequencer
    import bcd_digit_sequencer_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = 24,
    parameter int unsigned DIV_COUNT  = 12500000,
    parameter int unsigned DEB_WIDTH  = 18,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter int unsigned MAX_VAL    = DEFAULT_MAX_VAL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_run,
    input  logic               dir,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] num,
    output logic               running,
    output logic               tick,
    output logic               wrap
);

    localparam logic [DIV_WIDTH-1:0] DIV_TERM  = DIV_WIDTH'(DIV_COUNT - 1);
    localparam logic [DIGIT_W-1:0]   MAX_DIGIT = DIGIT_W'(MAX_VAL);

    run_state_e           state_q;
    run_state_e           state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic [DIGIT_W-1:0]   num_q;
    logic [DIGIT_W-1:0]   num_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 wrap_q;
    logic                 wrap_d;
    logic                 press;
    logic                 step;
    step_result_t         step_res;

    btn_debounce #(
        .DEB_WIDTH  (DEB_WIDTH),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_run (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_run),
        .press  (press)
    );

    // Run/pause FSM: every accepted press flips the state; load is ignored.
    always_comb begin
        state_d = state_q;
        if (press) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    // Prescaler and digit datapath; load wins over a coincident step.
    always_comb begin
        div_cnt_d = div_cnt_q;
        num_d     = num_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        step      = 1'b0;
        step_res  = step_digit(num_q, dir, MAX_DIGIT);
        if (state_q == ST_RUN) begin
            if (div_cnt_q >= DIV_TERM) begin
                div_cnt_d = '0;
                step      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
        end
        if (load) begin
            num_d     = clamp_load(load_val, MAX_DIGIT);
            div_cnt_d = '0;
        end else if (step) begin
            num_d  = step_res.digit;
            tick_d = 1'b1;
            wrap_d = step_res.wrap;
        end
    end

    // State, prescaler, digit and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_PAUSE;
            div_cnt_q <= '0;
            num_q     <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            num_q     <= num_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign num     = num_q;
    assign running = (state_q == ST_RUN);
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: doc/bcd_digit_sequencer.md
Name: bcd_digit_sequencer

Overview:
- Upstream stage of the 4-bit-to-7-segment decoder. Produces the 4-bit digit code `num` that the decoder renders.
- Steps a BCD digit 0..MAX_VAL at a prescaled rate. Supports up/down direction and synchronous load.
- Start/pause is controlled by a debounced push-button.
- Lives in the display lab datapath: button/switch inputs -> this block -> decoder -> segment pins.

Parameters:
- DIV_WIDTH, 24, width of prescaler counter.
- DIV_COUNT, 12500000, clocks per step tick (4 Hz at 50 MHz); legal range 2..2^DIV_WIDTH-1.
- DEB_WIDTH, 18, width of debounce counter.
- DEB_CYCLES, 250000, consecutive stable clocks required to accept a button level; legal range 1..2^DEB_WIDTH-1.
- MAX_VAL, 9, highest digit value; legal range 1..15.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- btn_run, input, 1, raw asynchronous push-button; each accepted press toggles run/pause.
- dir, input, 1, 1 = count up, 0 = count down.
- load, input, 1, synchronous load strobe (assumed synchronous to clk).
- load_val, input, 4, value loaded on load.
- num, output, 4, current digit to the decoder.
- running, output, 1, 1 while in RUN state.
- tick, output, 1, one-cycle pulse coincident with each num step.
- wrap, output, 1, one-cycle pulse when a step wraps (MAX_VAL->0 up, 0->MAX_VAL down).

Behaviour:
- Reset (rst_n low, asynchronous): num=0, running=0, tick=0, wrap=0. Prescaler=0, debounce counter=0, sync flops=0, debounced level=0, edge-detect flop=0. Release is synchronous to clk by the 2-flop rule of the top level.
- Button path:
  - btn_run passes through a 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEB_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - A rising edge of the debounced level produces one internal press pulse.
  - Press latency: 2 sync cycles + DEB_CYCLES + 1 cycle.
  - Glitches shorter than DEB_CYCLES clocks are ignored entirely.
- Run FSM, 2 states:
  - PAUSE (reset state): press -> RUN.
  - RUN: press -> PAUSE.
  - running = (state == RUN), registered.
- Prescaler:
  - In RUN it counts 0..DIV_COUNT-1.
  - At DIV_COUNT-1 it returns to 0 and a step occurs on the same edge.
  - In PAUSE it holds its value; resuming continues from the held count, with no restart.
- Step (same edge for num, tick, wrap):
  - dir is sampled on the step edge.
  - Up: num==MAX_VAL -> 0 with wrap=1; otherwise num+1.
  - Down: num==0 -> MAX_VAL with wrap=1; otherwise num-1.
  - tick=1 for exactly that cycle. tick and wrap are 0 on all other cycles.
- Load (highest priority):
  - When load=1, num takes load_val if load_val <= MAX_VAL, else 0.
  - Prescaler clears to 0.
  - tick=0 and wrap=0 that cycle, even if the prescaler was at terminal count.
  - Run state is unaffected. A press and a load in the same cycle both take effect.
- Arithmetic: num is always within 0..MAX_VAL. All increments are width-safe; no values 10..15 ever reach the decoder when MAX_VAL=9.
- Asynchronous reset mid-operation: all state returns immediately to reset values, and the block resumes in PAUSE showing 0.

Decomposition:
- Shared package: state encoding (ST_PAUSE, ST_RUN), digit width constant DIGIT_W=4, default MAX_VAL.
- One sub-module: btn_debounce (synchronizer + debounce counter + rising-edge pulse; parameters DEB_WIDTH, DEB_CYCLES). It is reusable for other lab buttons.
- Prescaler, FSM and digit counter stay in the top module.

Test Plan:
Every scenario uses DIV_COUNT=4, DEB_CYCLES=3, MAX_VAL=9.
- Reset: hold rst_n=0 with btn_run=1 -> num=0, running=0, tick=0, wrap=0. After release, no toggle until btn_run has been seen stable high for 3 clocks post-sync.
- Run up: one press with dir=1 -> running=1. tick every 4 clocks; num steps 0,1,...,9,0. wrap=1 only on the 9->0 cycle.
- Down and wrap: load=1 with load_val=2, then run with dir=0 -> num 2,1,0,9,8. wrap on the 0->9 step only.
- Bounce rejection: btn_run toggles every 1-2 clocks for 20 clocks, then settles low -> running unchanged. A clean 5-clock high pulse then toggles running exactly once.
- Pause/resume: pause with prescaler at 2, wait 50 clocks -> num constant, no tick. After resume, the first tick arrives after exactly 2 more clocks.
- Load boundary: load_val=12 -> num=0. Then load asserted on a prescaler-terminal cycle with load_val=5 -> num=5, tick=0, and the next tick arrives 4 clocks later.
